// File: rtl/uart_rx_cfg.sv
// Configurable-format UART receiver: elaboration-time frame format, run-time bit period,
// valid/ready output register with per-word parity/framing flags and overrun pulse.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int DIV_WIDTH   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 uart_clock,
  input  logic                 uart_reset,
  input  logic                 uart_d_in,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic [DATA_BITS-1:0] uart_d_out,
  output logic                 uart_valid,
  input  logic                 uart_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int                   IDX_W   = $clog2(DATA_BITS + 1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic                 PAR_ODD = (PARITY_ODD != 0);
  localparam logic [IDX_W-1:0]     LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]     LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_cfg: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DELIVER
  } state_t;

  state_t                 state_q,   state_d;
  logic [SYNC_STAGES-1:0] sync_q,    sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [DIV_WIDTH-1:0]   cnt_q,     cnt_d;
  logic [DIV_WIDTH-1:0]   div_q,     div_d;
  logic [IDX_W-1:0]       idx_q,     idx_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic                   perr_q,    perr_d;
  logic                   ferr_q,    ferr_d;
  logic [DATA_BITS-1:0]   dout_q,    dout_d;
  logic                   valid_q,   valid_d;
  logic                   pe_out_q,  pe_out_d;
  logic                   fe_out_q,  fe_out_d;
  logic                   ovr_q,     ovr_d;

  logic                   rx_s;
  logic                   cnt_done;
  logic [DIV_WIDTH-1:0]   div_eff;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_done = (cnt_q == '0);
  assign div_eff  = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], uart_d_in};
    rx_prev_d = rx_s;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    pe_out_d  = pe_out_q;
    fe_out_d  = fe_out_q;
    ovr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rx_prev_q must be high, so a line held low after a frame never re-triggers
        if (rx_prev_q && !rx_s) begin
          div_d   = div_eff;
          cnt_d   = (div_eff >> 1) - ONE;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - ONE;
        end else if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = div_q - ONE;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - ONE;
        end else begin
          // LSB-first right shift: after DATA_BITS samples the first bit sits at bit 0
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = div_q - ONE;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - ONE;
        end else begin
          perr_d  = ((^shift_q) ^ rx_s) != PAR_ODD;
          cnt_d   = div_q - ONE;
          idx_d   = '0;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - ONE;
        end else begin
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
          if (idx_q == LAST_STOP) begin
            state_d = S_DELIVER;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = div_q - ONE;
          end
        end
      end

      S_DELIVER: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output register: a held, unaccepted word wins over a newly completed frame
    if (state_q == S_DELIVER) begin
      if (!valid_q || uart_ready) begin
        dout_d   = shift_q;
        pe_out_d = perr_q;
        fe_out_d = ferr_q;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && uart_ready) begin
      valid_d  = 1'b0;
      pe_out_d = 1'b0;
      fe_out_d = 1'b0;
    end
  end

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      state_q   <= S_IDLE;
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      pe_out_q  <= 1'b0;
      fe_out_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      pe_out_q  <= pe_out_d;
      fe_out_q  <= fe_out_d;
      ovr_q     <= ovr_d;
    end
  end

  assign uart_d_out = dout_q;
  assign uart_valid = valid_q;
  assign parity_err = pe_out_q;
  assign frame_err  = fe_out_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, directed frames,
// expected words queued at send time and checked by per-instance monitors on handshake.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        rx_p = 1'b1;
  logic [23:0] baud_div = 24'd16;
  logic        ready = 1'b1;
  logic        ready_p = 1'b1;

  logic [7:0]  dout, dout_p;
  logic        v, v_p, pe, pe_p, fe, fe_p, ovr, ovr_p;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .DIV_WIDTH(24), .SYNC_STAGES(2)
  ) dut (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(rx), .baud_div(baud_div),
    .uart_d_out(dout), .uart_valid(v), .uart_ready(ready),
    .parity_err(pe), .frame_err(fe), .overrun(ovr)
  );

  uart_rx_cfg #(
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .DIV_WIDTH(24), .SYNC_STAGES(2)
  ) dut_p (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(rx_p), .baud_div(baud_div),
    .uart_d_out(dout_p), .uart_valid(v_p), .uart_ready(ready_p),
    .parity_err(pe_p), .frame_err(fe_p), .overrun(ovr_p)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_pq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rise = 0;
  int rise_cyc = 0;
  int n_ovr = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Monitor for the 8N1 instance
  initial begin : mon_main
    exp_t e;
    logic vprev;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (v && !vprev) begin
          n_rise++;
          rise_cyc = cyc;
        end
        if (ovr) n_ovr++;
        if (v && ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%0h, none expected", dout);
          end else begin
            e = exp_q.pop_front();
            chk("d_out", 32'(dout), 32'(e.d));
            chk("parity_err", 32'(pe), 32'(e.pe));
            chk("frame_err", 32'(fe), 32'(e.fe));
          end
        end
      end
      vprev = v;
    end
  end

  // Monitor for the 8E1 instance
  initial begin : mon_par
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && v_p && ready_p) begin
        if (exp_pq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word_p: got 0x%0h, none expected", dout_p);
        end else begin
          e = exp_pq.pop_front();
          chk("d_out_p", 32'(dout_p), 32'(e.d));
          chk("parity_err_p", 32'(pe_p), 32'(e.pe));
          chk("frame_err_p", 32'(fe_p), 32'(e.fe));
        end
      end
    end
  end

  function automatic logic [15:0] f8(input logic [7:0] d, input logic stop);
    return {6'h3f, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] fpar(input logic [7:0] d, input logic pbit);
    return {5'h1f, 1'b1, pbit, d, 1'b0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; each bit held for div clocks, LSB first, line left high
  task automatic send(input bit p, input logic [15:0] bits, input int nbits, input int div);
    for (int i = 0; i < nbits; i++) begin
      if (p) rx_p = bits[i];
      else   rx   = bits[i];
      if (i == 0) start_cyc = cyc;
      idle(div);
    end
    if (p) rx_p = 1'b1;
    else   rx   = 1'b1;
  endtask

  task automatic drain(input bit p);
    int n;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      n = p ? exp_pq.size() : exp_q.size();
      if (n == 0) break;
      @(posedge clk);
    end
    #1;
    n = p ? exp_pq.size() : exp_q.size();
    chk(p ? "drain_p" : "drain", 32'(n), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;
    int o0;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(v), 32'd0);
    chk("rst_d_out", 32'(dout), 32'd0);
    chk("rst_parity_err", 32'(pe), 32'd0);
    chk("rst_frame_err", 32'(fe), 32'd0);
    chk("rst_overrun", 32'(ovr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    // T1: 8N1 0xA5 at div 16, latency and single valid pulse
    r0 = n_rise;
    exp_q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send(1'b0, f8(8'hA5, 1'b1), 10, 16);
    idle(30);
    drain(1'b0);
    chk("t1_valid_pulses", 32'(n_rise - r0), 32'd1);
    chk_rng("t1_latency", rise_cyc - start_cyc - 1, 154, 156);

    // T2: even parity, 0x07 with wrong then right parity bit
    exp_pq.push_back('{d: 8'h07, pe: 1'b1, fe: 1'b0});
    send(1'b1, fpar(8'h07, 1'b0), 11, 16);
    idle(30);
    drain(1'b1);
    exp_pq.push_back('{d: 8'h07, pe: 1'b0, fe: 1'b0});
    send(1'b1, fpar(8'h07, 1'b1), 11, 16);
    idle(30);
    drain(1'b1);

    // T3: stop bit low gives frame_err, next frame clean
    exp_q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
    send(1'b0, f8(8'h3C, 1'b0), 10, 16);
    idle(30);
    exp_q.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0});
    send(1'b0, f8(8'h55, 1'b1), 10, 16);
    idle(30);
    drain(1'b0);

    // T4: consumer stalled, second frame dropped with one overrun pulse
    ready = 1'b0;
    o0 = n_ovr;
    exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send(1'b0, f8(8'h11, 1'b1), 10, 16);
    idle(20);
    send(1'b0, f8(8'h22, 1'b1), 10, 16);
    idle(30);
    chk("t4_overrun_pulses", 32'(n_ovr - o0), 32'd1);
    chk("t4_valid_held", 32'(v), 32'd1);
    chk("t4_d_out_held", 32'(dout), 32'h11);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid_dropped", 32'(v), 32'd0);
    idle(2);
    drain(1'b0);

    // T5: 3-clock low glitch is a false start
    r0 = n_rise;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    chk("t5_no_valid", 32'(n_rise - r0), 32'd0);
    exp_q.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
    send(1'b0, f8(8'h81, 1'b1), 10, 16);
    idle(30);
    drain(1'b0);

    // T6: reset in the middle of data bit 3 of 0xC3
    b = 8'hC3;
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      idle(16);
    end
    rx = b[3];
    idle(8);
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", 32'(v), 32'd0);
    chk("t6_rst_d_out", 32'(dout), 32'd0);
    chk("t6_rst_parity_err", 32'(pe), 32'd0);
    chk("t6_rst_frame_err", 32'(fe), 32'd0);
    chk("t6_rst_overrun", 32'(ovr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    r0 = n_rise;
    idle(200);
    chk("t6_aborted_no_valid", 32'(n_rise - r0), 32'd0);

    // baud_div changed mid-frame: this frame stays at 16, the next one uses 32
    exp_q.push_back('{d: 8'hF0, pe: 1'b0, fe: 1'b0});
    fork
      send(1'b0, f8(8'hF0, 1'b1), 10, 16);
      begin
        idle(60);
        baud_div = 24'd32;
      end
    join
    idle(30);
    drain(1'b0);
    exp_q.push_back('{d: 8'h3A, pe: 1'b0, fe: 1'b0});
    send(1'b0, f8(8'h3A, 1'b1), 10, 32);
    idle(40);
    drain(1'b0);

    // Divisor below 4 is clamped to 4 clocks per bit
    baud_div = 24'd2;
    exp_q.push_back('{d: 8'h96, pe: 1'b0, fe: 1'b0});
    send(1'b0, f8(8'h96, 1'b1), 10, 4);
    idle(20);
    drain(1'b0);

    chk("total_overruns", 32'(n_ovr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
